// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types for the writeback-port arbiter and its scoreboard.
//   reg_idx_t  : 4-bit architectural register index (r0..r15)
//   REG_ZERO   : r0, hard-wired zero; never written and never busy
//   NUM_REGS   : size of the register file
//   wb_state_t : arbitration FSM states (IDLE / HOLD / FORCE)
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef logic [3:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 4'h0;
   localparam int       NUM_REGS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FORCE = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Busy bitmap for registers that have an outstanding coprocessor write.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears busy)
//   set_en, set_idx     coprocessor issue: mark set_idx busy
//   clr_en, clr_idx     held result granted: mark clr_idx free
//   id_sr1/id_sr2/id_dest  decode-stage register indices to look up
//   id_hazard           decode must stall (any looked-up register busy)
// -----------------------------------------------------------------------------
module wb_scoreboard
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     set_en,
   input  reg_idx_t set_idx,
   input  logic     clr_en,
   input  reg_idx_t clr_idx,
   input  reg_idx_t id_sr1,
   input  reg_idx_t id_sr2,
   input  reg_idx_t id_dest,
   output logic     id_hazard
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         if (gi == 0) begin : g_r0
            // r0 is never written, so it can never be outstanding.
            assign busy_d[gi] = 1'b0;
         end else begin : g_rn
            // Set has priority: a new issue to a register whose previous
            // result is retiring this cycle keeps it busy.
            always_comb begin
               busy_d[gi] = busy_q[gi];
               if (clr_en && (clr_idx == reg_idx_t'(gi)))
                  busy_d[gi] = 1'b0;
               if (set_en && (set_idx == reg_idx_t'(gi)))
                  busy_d[gi] = 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign id_hazard = ((id_sr1  != REG_ZERO) && busy_q[id_sr1])
                    | ((id_sr2  != REG_ZERO) && busy_q[id_sr2])
                    | ((id_dest != REG_ZERO) && busy_q[id_dest]);

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// (MEM/WB) and a long-latency coprocessor. One coprocessor result is held and
// granted when the pipeline leaves the port idle; after MAX_WAIT denied cycles
// the pipeline is stalled for one cycle and the held result is forced through.
// Optional feature macro: WB_FORCE_STATS_EN adds a saturating 16-bit
// force_count output counting FORCE cycles.
// Parameters: DATA_W (writeback width), MAX_WAIT (1..15 denied cycles).
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   pipe_wb_en/dest/data         pipeline writeback request
//   cop_issue_en/dest            coprocessor issue (marks dest busy)
//   cop_valid/dest/data, cop_ready  coprocessor result handshake
//   id_sr1/id_sr2/id_dest, id_hazard  decode hazard lookup
//   pipe_stall                   freeze MEM/WB this cycle (FORCE)
//   wb_en/wb_dest/wb_data        registered register-file write port
//   force_count                  (WB_FORCE_STATS_EN only) FORCE cycle count
// -----------------------------------------------------------------------------
module wb_port_arbiter
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_wb_en,
   input  reg_idx_t          pipe_wb_dest,
   input  logic [DATA_W-1:0] pipe_wb_data,
   input  logic              cop_issue_en,
   input  reg_idx_t          cop_issue_dest,
   input  logic              cop_valid,
   input  reg_idx_t          cop_dest,
   input  logic [DATA_W-1:0] cop_data,
   output logic              cop_ready,
   input  reg_idx_t          id_sr1,
   input  reg_idx_t          id_sr2,
   input  reg_idx_t          id_dest,
   output logic              id_hazard,
   output logic              pipe_stall,
`ifdef WB_FORCE_STATS_EN
   output logic [15:0]       force_count,
`endif
   output logic              wb_en,
   output reg_idx_t          wb_dest,
   output logic [DATA_W-1:0] wb_data
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   wb_state_t         state_q, state_d;
   logic              hold_valid_q, hold_valid_d;
   reg_idx_t          hold_dest_q, hold_dest_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              wb_en_q, wb_en_d;
   reg_idx_t          wb_dest_q, wb_dest_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic              grant_hold;
   logic              stall;
   logic              sel_en;
   reg_idx_t          sel_dest;
   logic [DATA_W-1:0] sel_data;

   // Arbitration FSM: next state, hold register and grant select.
   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_dest_d  = hold_dest_q;
      hold_data_d  = hold_data_q;
      wait_cnt_d   = wait_cnt_q;
      grant_hold   = 1'b0;
      stall        = 1'b0;

      case (state_q)
         IDLE: begin
            // Hold is empty here, so cop_ready is high and any valid
            // result is accepted; it can be granted no earlier than next cycle.
            if (cop_valid) begin
               hold_valid_d = 1'b1;
               hold_dest_d  = cop_dest;
               hold_data_d  = cop_data;
               wait_cnt_d   = 4'd0;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (!pipe_wb_en) begin
               grant_hold = 1'b1;
               wait_cnt_d = 4'd0;
               state_d    = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
               if ((wait_cnt_q + 4'd1) == MAX_WAIT_C)
                  state_d = FORCE;
            end
         end
         FORCE: begin
            // Pipeline write this cycle is dropped; pipeline re-presents it.
            stall      = 1'b1;
            grant_hold = 1'b1;
            wait_cnt_d = 4'd0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The granted slot is freed; refill waits for the next cycle.
      if (grant_hold)
         hold_valid_d = 1'b0;
   end

   // Write-port mux; r0 writes are consumed but never reach the register file,
   // and the address/data registers keep their last real write.
   always_comb begin
      sel_en    = grant_hold ? 1'b1        : pipe_wb_en;
      sel_dest  = grant_hold ? hold_dest_q : pipe_wb_dest;
      sel_data  = grant_hold ? hold_data_q : pipe_wb_data;
      wb_en_d   = sel_en && (sel_dest != REG_ZERO);
      wb_dest_d = wb_en_d ? sel_dest : wb_dest_q;
      wb_data_d = wb_en_d ? sel_data : wb_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_valid_q <= 1'b0;
         hold_dest_q  <= REG_ZERO;
         hold_data_q  <= '0;
         wait_cnt_q   <= 4'd0;
         wb_en_q      <= 1'b0;
         wb_dest_q    <= REG_ZERO;
         wb_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_dest_q  <= hold_dest_d;
         hold_data_q  <= hold_data_d;
         wait_cnt_q   <= wait_cnt_d;
         wb_en_q      <= wb_en_d;
         wb_dest_q    <= wb_dest_d;
         wb_data_q    <= wb_data_d;
      end
   end

`ifdef WB_FORCE_STATS_EN
   logic [15:0] force_count_q, force_count_d;

   always_comb begin
      force_count_d = force_count_q;
      if ((state_q == FORCE) && (force_count_q != 16'hFFFF))
         force_count_d = force_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         force_count_q <= 16'd0;
      else
         force_count_q <= force_count_d;
   end

   assign force_count = force_count_q;
`endif

   wb_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (cop_issue_en),
      .set_idx   (cop_issue_dest),
      .clr_en    (grant_hold),
      .clr_idx   (hold_dest_q),
      .id_sr1    (id_sr1),
      .id_sr2    (id_sr2),
      .id_dest   (id_dest),
      .id_hazard (id_hazard)
   );

   assign cop_ready  = !hold_valid_q;
   assign pipe_stall = stall;
   assign wb_en      = wb_en_q;
   assign wb_dest    = wb_dest_q;
   assign wb_data    = wb_data_q;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (MEM/WB writeback) between the in-order pipeline and a long-latency coprocessor (memory/NN accelerator result path).
- Holds one pending coprocessor result and grants it when the pipeline leaves the port idle.
- Forces a pipeline stall if the pending result starves; keeps a 16-entry busy scoreboard so decode stalls on registers with outstanding coprocessor writes.
- Registered writeback outputs feed the register file and the forwarding unit.

Parameters:
DATA_W, 16, width of writeback data
MAX_WAIT, 4, cycles a held coprocessor result may be denied before a forced grant (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pipe_wb_en  in  1  pipeline writeback request
pipe_wb_dest  in  4  pipeline destination register
pipe_wb_data  in  DATA_W  pipeline writeback data
cop_issue_en  in  1  coprocessor op issued this cycle; marks destination busy
cop_issue_dest  in  4  destination of issued coprocessor op
cop_valid  in  1  coprocessor result valid
cop_dest  in  4  coprocessor result destination
cop_data  in  DATA_W  coprocessor result data
cop_ready  out  1  holding register free; result accepted on cop_valid && cop_ready
id_sr1, id_sr2, id_dest  in  4 each  decode-stage source and destination registers
id_hazard  out  1  decode must stall (RAW/WAW on a busy register)
pipe_stall  out  1  freeze MEM/WB; pipeline re-presents the same write next cycle
wb_en  out  1  register-file write enable (registered)
wb_dest  out  4  register-file write address (registered)
wb_data  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async): wb_en=0, wb_dest=0, wb_data=0, hold empty, wait_cnt=0, busy=0, state=IDLE. Combinational outputs after reset: cop_ready=1, pipe_stall=0, id_hazard=0.
- cop_ready = !hold_valid, combinational. Accept on cop_valid && cop_ready: capture dest and data into the hold register. Earliest grant is the next cycle.
- States:
  - IDLE: hold empty.
  - HOLD: hold_valid; wait_cnt counts denied cycles.
  - FORCE: wait_cnt == MAX_WAIT.
- Grant rule, evaluated each cycle:
  - IDLE: grant pipe.
  - HOLD with pipe_wb_en=0: grant hold, next state IDLE.
  - HOLD with pipe_wb_en=1: grant pipe, wait_cnt+1; on reaching MAX_WAIT, next state FORCE.
  - FORCE: pipe_stall=1 (combinational, this cycle only), grant hold, wait_cnt cleared, next state IDLE.
- Granting hold in a cycle frees it: cop_ready goes high the next cycle. No same-cycle refill.
- Write latency is 1 cycle: the granted request appears on wb_* at the next rising edge. No grant (or a grant with en=0) drives wb_en=0 and holds the last wb_dest/wb_data.
- Writes to r0 are suppressed: wb_en=0 whenever the granted dest==0, from either source. A held r0 result is still consumed.
- Scoreboard, busy[15:0], with r0 never set:
  - Set busy[cop_issue_dest] on cop_issue_en.
  - Clear busy[hold_dest] on the cycle hold is granted.
  - Set and clear of the same register in the same cycle: set wins.
- id_hazard = busy[id_sr1] | busy[id_sr2] | busy[id_dest], with r0 always ignored. Combinational from the registered busy bits.
- pipe_wb_en during FORCE is not written. The pipeline must hold MEM/WB on pipe_stall and re-present the write next cycle; the arbiter keeps no copy of it.
- A reset mid-operation discards the held result and clears busy. The coprocessor must be reset on the same rst.

Optional Feature:
- WB_FORCE_STATS_EN defined: adds output force_count (16 bits), reset 0. It increments on every FORCE cycle and saturates at 16'hFFFF.
- Undefined: no port, no counter; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg: reg_idx_t (4-bit), REG_ZERO=4'h0, the wb_state_t enum (IDLE/HOLD/FORCE).
- One sub-module: wb_scoreboard, holding the busy bitmap plus the set/clear/lookup logic and the id_hazard output. Arbitration FSM and hold register stay in wb_port_arbiter.

Test Plan:
- Pipe-only: pipe writes r3=0x1234 → next cycle wb_en=1, wb_dest=3, wb_data=0x1234; write to r0 → wb_en=0.
- Idle-port grant: cop result r5=0xBEEF with pipe_wb_en=0 → captured; cop_ready=0 next cycle; wb r5=0xBEEF one cycle after grant; cop_ready back to 1.
- Starvation (MAX_WAIT=4): hold r7 while pipe_wb_en=1 continuously → 4 pipe writes pass, then pipe_stall=1 for exactly one cycle; r7 written; the stalled pipe write lands the cycle after.
- Scoreboard RAW: issue r9; id_sr2=9 → id_hazard=1 until the r9 writeback grant cycle, 0 the next cycle; id_sr1=0 never hazards.
- Set/clear collision: r4 granted from hold in the same cycle as cop_issue_dest=4 → busy[4] stays 1.
- Reset mid-HOLD: assert rst with hold valid → wb_en=0, cop_ready=1, busy=0 immediately; with WB_FORCE_STATS_EN, force_count=0.
